hazunit_sb: RTL
===============

Name: hazunit_sb

Overview:
- Next-generation hazard unit for the 5-stage pipeline: F, D, E, M, W.
- Keeps the existing functions: E-stage forwarding, D-stage branch forwarding, load-use stall, branch stall.
- Adds a parametrised register file size and a registered scoreboard for one in-flight multi-cycle (mult/div) operation of fixed latency.
- Sits beside the datapath; drives stall/flush/forward selects; owns the MD-unit completion timing.

Parameters:
- NREG, 32: architectural registers; register 0 is hard-wired zero and never a hazard source.
- RW, $clog2(NREG): register-index width.
- MD_LAT, 4: cycles from MD issue in E to result available in W-writeback (legal range 2..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- hazreset  in  1  sync override; forces stallF/stallD/flushE to 0 (scoreboard still advances).
- branchD  in  1  branch in D.
- mdD  in  1  MD instruction in D.
- rsD, rtD, rsE, rtE  in  RW  source indices.
- writeregE, writeregM, writeregW  in  RW  destinations.
- memtoregE, regwriteE, memtoregM, regwriteM, regwriteW  in  1  stage controls.
- mdstartE  in  1  MD op issuing from E this cycle.
- mdregE  in  RW  MD destination.
- forwardAE, forwardBE  out  2  00 reg file, 01 W result, 10 M result.
- forwardAD, forwardBD  out  1  D-stage compare operands taken from M.
- stallF, stallD, flushE  out  1  pipeline control.
- md_busy  out  1  MD op in flight.
- md_done  out  1  one-cycle pulse: MD result written this cycle.
- md_wreg  out  RW  destination of the completing MD op.

Behaviour:
- Reset (rst_n low, async): md_busy=0, md_done=0, md_wreg=0, counter=0, pending reg=0.
- Combinational outputs follow their equations immediately after reset.
- forwardAE/BE: M match has priority over W match.
  - M match: src!=0, src==writeregM, regwriteM.
  - W match: src!=0, src==writeregW, regwriteW.
- forwardAD/BD: src!=0 & src==writeregM & regwriteM.
- lwstall: memtoregE & rtE!=0 & (rsD==rtE | rtD==rtE). Zero-index qualifier is new behaviour.
- branchstall, either of:
  - branchD & regwriteE & writeregE!=0 & writeregE matches rsD or rtD;
  - branchD & memtoregM & writeregM!=0 & writeregM matches rsD or rtD.
- mdstall, either of:
  - md_busy & pend!=0 & (rsD==pend | rtD==pend);
  - md_busy & mdD & !(cnt==1): a second MD may enter E only in the last busy cycle.
- stall = lwstall | branchstall | mdstall.
  - stallF = stallD = flushE = stall & !hazreset.
- Scoreboard FSM, states IDLE and BUSY:
  - IDLE + mdstartE: pend<=mdregE, cnt<=MD_LAT-1, go BUSY.
  - BUSY: cnt decrements each cycle. At cnt==1 the next edge asserts md_done with md_wreg=pend.
    - Without a new start: go IDLE, md_busy=0.
    - If mdstartE in that same cycle: reload pend/cnt and stay BUSY (back-to-back, zero-bubble).
  - mdstartE in BUSY with cnt!=1: protocol error. Ignored; state is unchanged.
- md_busy is high in BUSY.
- md_done is registered and high exactly one cycle, MD_LAT cycles after the mdstartE cycle.
- mdregE==0: the op is tracked for timing, but pend=0 causes no stall.
- Reset mid-operation aborts the MD op; no md_done is produced.

Optional Feature:
- Macro HAZ_PERFCNT_EN.
- Defined: adds outputs stall_cnt[31:0] and md_stall_cnt[31:0].
  - stall_cnt counts cycles where stallD=1.
  - md_stall_cnt counts cycles where mdstall & !hazreset.
  - Both saturate at all-ones and reset to 0 on rst_n.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Forwarding priority: rsE=5, writeregM=5, writeregW=5, both regwrite=1 -> forwardAE=10. Set regwriteM=0 -> 01. Set rsE=0 -> 00.
- Load-use: memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1. Raise hazreset -> all 0. rtE=0 -> no stall.
- Branch: branchD=1, regwriteE=1, writeregE=3, rtD=3 -> stall. Next cycle memtoregM=1, writeregM=3 -> stall. writeregM=4 -> no stall, forwardBD=0.
- MD latency: MD_LAT=4, mdstartE with mdregE=9 at cycle 0.
  - md_busy=1 during cycles 1-3.
  - md_done=1 and md_wreg=9 in cycle 4 only.
  - rsD=9 stalls in cycles 1-3 and releases in cycle 4.
- Back-to-back MD: mdD=1 while busy -> stalled until cnt==1; mdstartE there -> md_done for the first op, md_busy stays 1, the second op completes 4 cycles later.
- Async reset during BUSY (cycle 2) -> md_busy=0 immediately, no md_done afterward. With HAZ_PERFCNT_EN defined, stall_cnt reads 0.

Source files
------------

// File: rtl/hazunit_sb.sv
// hazunit_sb: 5-stage pipeline hazard unit with a scoreboard for one fixed-latency mult/div op.
// Optional macro HAZ_PERFCNT_EN adds saturating stall_cnt / md_stall_cnt outputs.
module hazunit_sb #(
    parameter int NREG   = 32,
    parameter int RW     = $clog2(NREG),
    parameter int MD_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hazreset,
    input  logic          branchD,
    input  logic          mdD,
    input  logic [RW-1:0] rsD,
    input  logic [RW-1:0] rtD,
    input  logic [RW-1:0] rsE,
    input  logic [RW-1:0] rtE,
    input  logic [RW-1:0] writeregE,
    input  logic [RW-1:0] writeregM,
    input  logic [RW-1:0] writeregW,
    input  logic          memtoregE,
    input  logic          regwriteE,
    input  logic          memtoregM,
    input  logic          regwriteM,
    input  logic          regwriteW,
    input  logic          mdstartE,
    input  logic [RW-1:0] mdregE,
    output logic [1:0]    forwardAE,
    output logic [1:0]    forwardBE,
    output logic          forwardAD,
    output logic          forwardBD,
    output logic          stallF,
    output logic          stallD,
    output logic          flushE,
    output logic          md_busy,
    output logic          md_done,
`ifdef HAZ_PERFCNT_EN
    output logic [31:0]   stall_cnt,
    output logic [31:0]   md_stall_cnt,
`endif
    output logic [RW-1:0] md_wreg
);

    localparam int CW = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] pend_q, pend_d;
    logic [RW-1:0] md_wreg_q, md_wreg_d;
    logic          md_done_q, md_done_d;

    logic          busy;
    logic          last_busy;
    logic          lwstall;
    logic          branchstall;
    logic          mdstall;
    logic          stall_out;

    // Operand 0 is the rs path, operand 1 the rt path.
    logic [1:0][RW-1:0] src_e;
    logic [1:0][RW-1:0] src_d;
    logic [1:0][1:0]    fwd_e;
    logic [1:0]         fwd_d;
    logic [1:0]         br_hit_e;
    logic [1:0]         br_hit_m;
    logic [1:0]         md_hit;

    assign src_e[0] = rsE;
    assign src_e[1] = rtE;
    assign src_d[0] = rsD;
    assign src_d[1] = rtD;

    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
        logic m_hit;
        logic w_hit;

        assign m_hit        = (src_e[gi] != '0) && (src_e[gi] == writeregM) && regwriteM;
        assign w_hit        = (src_e[gi] != '0) && (src_e[gi] == writeregW) && regwriteW;
        // M result is younger than W result, so it wins when both match.
        assign fwd_e[gi]    = m_hit ? 2'b10 : (w_hit ? 2'b01 : 2'b00);
        assign fwd_d[gi]    = (src_d[gi] != '0) && (src_d[gi] == writeregM) && regwriteM;
        assign br_hit_e[gi] = (writeregE != '0) && (writeregE == src_d[gi]);
        assign br_hit_m[gi] = (writeregM != '0) && (writeregM == src_d[gi]);
        assign md_hit[gi]   = (pend_q != '0) && (pend_q == src_d[gi]);
    end

    assign forwardAE = fwd_e[0];
    assign forwardBE = fwd_e[1];
    assign forwardAD = fwd_d[0];
    assign forwardBD = fwd_d[1];

    assign busy      = (state_q == S_BUSY);
    assign last_busy = busy && (cnt_q == CW'(1));

    assign lwstall     = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
    assign branchstall = branchD && ((regwriteE && (|br_hit_e)) || (memtoregM && (|br_hit_m)));
    // A following MD op may only reach E in the final busy cycle so it can chain without a bubble.
    assign mdstall     = busy && ((|md_hit) || (mdD && !last_busy));
    assign stall_out   = (lwstall || branchstall || mdstall) && !hazreset;

    // Scoreboard: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            md_wreg_q <= '0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            md_wreg_q <= md_wreg_d;
            md_done_q <= md_done_d;
        end
    end

    // Scoreboard: next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        md_wreg_d = md_wreg_q;
        md_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mdstartE) begin
                    state_d = S_BUSY;
                    cnt_d   = CW'(MD_LAT - 1);
                    pend_d  = mdregE;
                end
            end
            S_BUSY: begin
                if (last_busy) begin
                    md_done_d = 1'b1;
                    md_wreg_d = pend_q;
                    if (mdstartE) begin
                        cnt_d  = CW'(MD_LAT - 1);
                        pend_d = mdregE;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    // An issue here is a protocol violation and is dropped.
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Scoreboard: outputs
    always_comb begin
        md_busy = busy;
        md_done = md_done_q;
        md_wreg = md_wreg_q;
        stallF  = stall_out;
        stallD  = stall_out;
        flushE  = stall_out;
    end

`ifdef HAZ_PERFCNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] md_stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            if (stall_out && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (mdstall && !hazreset && (md_stall_cnt_q != '1)) begin
                md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule
